// File: rtl/pe_os_mac.sv
// Output-stationary MAC processing element: forwards operands one cycle later and accumulates
// a saturating dot product that is handed to a single-entry, non-blocking result register.
module pe_os_mac #(
    parameter int BW     = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    input  logic             i_last,
    input  logic             i_clear,
    input  logic             i_result_ready,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_valid,
    output logic             o_last,
    output logic [ACC_W-1:0] o_result,
    output logic             o_result_valid,
    output logic [CNT_W-1:0] o_result_count,
    output logic             o_result_sat,
    output logic             o_dropped
);
    localparam logic IS_SIGNED = (SIGNED != 0);

    logic             r_s1_valid, r_s1_last, r_s1_clear;
    logic [BW-1:0]    r_s1_act, r_s1_wgt;
    logic [ACC_W-1:0] r_acc, r_result;
    logic [CNT_W-1:0] r_cnt, r_res_cnt;
    logic             r_sat, r_start, r_res_sat, r_res_vld, r_dropped;

    logic [ACC_W-1:0] w_a_ext, w_w_ext, w_prod, w_clamp, w_acc_add, w_acc_nxt;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf, w_fresh, w_sat_nxt, w_load;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_clear <= 1'b0;
            r_s1_act   <= '0;
            r_s1_wgt   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_last  <= i_last;
            r_s1_clear <= i_clear;
            r_s1_act   <= i_activation;
            r_s1_wgt   <= i_weight;
        end
    end

    // Extending both operands to ACC_W first keeps the low ACC_W product bits exact in either mode.
    assign w_a_ext = {{(ACC_W-BW){IS_SIGNED & r_s1_act[BW-1]}}, r_s1_act};
    assign w_w_ext = {{(ACC_W-BW){IS_SIGNED & r_s1_wgt[BW-1]}}, r_s1_wgt};
    assign w_prod  = w_a_ext * w_w_ext;

    assign w_sum   = {IS_SIGNED & r_acc[ACC_W-1], r_acc} + {IS_SIGNED & w_prod[ACC_W-1], w_prod};
    assign w_ovf   = IS_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_clamp = !IS_SIGNED    ? '1 :
                     w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};
    assign w_acc_add = w_ovf ? w_clamp : w_sum[ACC_W-1:0];

    assign w_fresh   = r_start | r_s1_clear;
    assign w_acc_nxt = w_fresh ? w_prod : w_acc_add;
    assign w_cnt_nxt = w_fresh ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
    assign w_sat_nxt = w_fresh ? 1'b0 : (r_sat | w_ovf);
    assign w_load    = r_s1_valid & r_s1_last;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_start   <= 1'b1;
            r_result  <= '0;
            r_res_cnt <= '0;
            r_res_sat <= 1'b0;
            r_res_vld <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            if (r_s1_valid) begin
                r_acc   <= w_acc_nxt;
                r_cnt   <= w_cnt_nxt;
                r_sat   <= w_sat_nxt;
                r_start <= r_s1_last;
            end else if (r_s1_clear) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_sat   <= 1'b0;
                r_start <= 1'b1;
            end
            // A new result always wins; an unaccepted one it replaces is flagged as lost.
            if (w_load) begin
                r_result  <= w_acc_nxt;
                r_res_cnt <= w_cnt_nxt;
                r_res_sat <= w_sat_nxt;
                r_res_vld <= 1'b1;
                if (r_res_vld && !i_result_ready)
                    r_dropped <= 1'b1;
            end else if (i_result_ready) begin
                r_res_vld <= 1'b0;
            end
        end
    end

    assign o_activation   = r_s1_act;
    assign o_weight       = r_s1_wgt;
    assign o_valid        = r_s1_valid;
    assign o_last         = r_s1_last;
    assign o_result       = r_result;
    assign o_result_valid = r_res_vld;
    assign o_result_count = r_res_cnt;
    assign o_result_sat   = r_res_sat;
    assign o_dropped      = r_dropped;

endmodule

// File: tb/tb_pe_os_mac.sv
// Bench for pe_os_mac: a signed and an unsigned instance share one operand stream; a term-level
// model queues expected results, and a negedge monitor checks results, drops and forwarding.
module tb_pe_os_mac;
    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0, i_last = 1'b0, i_clear = 1'b0, i_result_ready = 1'b1;
    logic [7:0] i_activation = '0, i_weight = '0;

    logic [7:0]  o_act [2];
    logic [7:0]  o_wgt [2];
    logic        o_fv  [2];
    logic        o_fl  [2];
    logic [19:0] o_res [2];
    logic        o_rv  [2];
    logic [7:0]  o_cnt [2];
    logic        o_sat [2];
    logic        o_drp [2];

    always #5 i_clock = ~i_clock;

    pe_os_mac #(.BW(8), .ACC_W(20), .CNT_W(8), .SIGNED(1)) u_dut_s (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_activation(i_activation), .i_weight(i_weight), .i_last(i_last),
        .i_clear(i_clear), .i_result_ready(i_result_ready),
        .o_activation(o_act[0]), .o_weight(o_wgt[0]), .o_valid(o_fv[0]), .o_last(o_fl[0]),
        .o_result(o_res[0]), .o_result_valid(o_rv[0]), .o_result_count(o_cnt[0]),
        .o_result_sat(o_sat[0]), .o_dropped(o_drp[0]));

    pe_os_mac #(.BW(8), .ACC_W(20), .CNT_W(8), .SIGNED(0)) u_dut_u (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_activation(i_activation), .i_weight(i_weight), .i_last(i_last),
        .i_clear(i_clear), .i_result_ready(i_result_ready),
        .o_activation(o_act[1]), .o_weight(o_wgt[1]), .o_valid(o_fv[1]), .o_last(o_fl[1]),
        .o_result(o_res[1]), .o_result_valid(o_rv[1]), .o_result_count(o_cnt[1]),
        .o_result_sat(o_sat[1]), .o_dropped(o_drp[1]));

    typedef struct {
        int          le;
        logic [19:0] res0, res1;
        logic [7:0]  cnt;
        logic        sat0, sat1;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0, failures = 0, edge_n = 0;
    longint m_acc[2];
    bit     m_sat[2];
    int     m_cnt = 0;
    bit     m_start = 1'b1;
    exp_t   pend;
    bit     pend_vld = 1'b0, m_drop = 1'b0;
    logic [7:0] prev_a, prev_w;
    logic   prev_v, prev_l;
    bit     prev_ok = 1'b0;

    always @(posedge i_clock) edge_n++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start = 1'b1;
        m_cnt   = 0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_sat[d] = 1'b0;
        end
    endtask

    // Drive one cycle of operands and advance the dot-product model by the same term.
    task automatic term(input logic v, input logic [7:0] a, input logic [7:0] w,
                        input logic l, input logic c);
        longint p, s, lo, hi;
        bit     fresh;
        exp_t   e;
        @(posedge i_clock);
        #1;
        i_valid = v; i_activation = a; i_weight = w; i_last = l; i_clear = c;
        if (!v) begin
            if (c) model_reset();
        end else begin
            fresh = m_start || c;
            for (int d = 0; d < 2; d++) begin
                p  = (d == 0) ? longint'($signed(a)) * longint'($signed(w)) : longint'(a) * longint'(w);
                lo = (d == 0) ? -524288 : 0;
                hi = (d == 0) ? 524287 : 1048575;
                if (fresh) begin
                    m_acc[d] = p;
                    m_sat[d] = 1'b0;
                end else begin
                    s = m_acc[d] + p;
                    if (s > hi) begin s = hi; m_sat[d] = 1'b1; end
                    if (s < lo) begin s = lo; m_sat[d] = 1'b1; end
                    m_acc[d] = s;
                end
            end
            m_cnt = fresh ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            if (l) begin
                e.le = edge_n + 2;
                e.res0 = 20'(m_acc[0]); e.res1 = 20'(m_acc[1]);
                e.cnt = 8'(m_cnt); e.sat0 = m_sat[0]; e.sat1 = m_sat[1];
                exp_q.push_back(e);
            end
            m_start = l;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) term(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge i_clock);
        #1;
        i_valid = 1'b0; i_last = 1'b0; i_clear = 1'b0;
        i_reset = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
    endtask

    // Monitor: retire expected results as they come due, then compare every visible output.
    initial begin
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                for (int d = 0; d < 2; d++) begin
                    chk("rst_result", o_res[d], 0);
                    chk("rst_flags", {o_rv[d], o_sat[d], o_drp[d], o_fv[d], o_fl[d]}, 0);
                    chk("rst_cnt_fwd", {o_cnt[d], o_act[d], o_wgt[d]}, 0);
                end
                pend_vld = 1'b0;
                m_drop   = 1'b0;
                prev_ok  = 1'b0;
                continue;
            end
            while (exp_q.size() > 0 && exp_q[0].le <= edge_n) begin
                if (pend_vld) m_drop = 1'b1;
                pend = exp_q.pop_front();
                pend_vld = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                chk("result_valid", o_rv[d], pend_vld);
                chk("dropped", o_drp[d], m_drop);
                if (pend_vld) begin
                    chk("result", o_res[d], (d == 0) ? pend.res0 : pend.res1);
                    chk("result_count", o_cnt[d], pend.cnt);
                    chk("result_sat", o_sat[d], (d == 0) ? pend.sat0 : pend.sat1);
                end
                if (prev_ok) begin
                    chk("fwd_act", o_act[d], prev_a);
                    chk("fwd_wgt", o_wgt[d], prev_w);
                    chk("fwd_valid_last", {o_fv[d], o_fl[d]}, {prev_v, prev_l});
                end
            end
            if (pend_vld && i_result_ready) pend_vld = 1'b0;
            prev_a = i_activation; prev_w = i_weight; prev_v = i_valid; prev_l = i_last;
            prev_ok = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b0;

        // Simple dot product: 1*5+2*6+3*7+4*8 = 70.
        term(1, 8'd1, 8'd5, 0, 0); term(1, 8'd2, 8'd6, 0, 0);
        term(1, 8'd3, 8'd7, 0, 0); term(1, 8'd4, 8'd8, 1, 0);
        idle(3);

        // Signed saturation at the 32nd term.
        for (int i = 0; i < 32; i++) term(1, 8'h80, 8'h80, (i == 31), 0);
        idle(3);

        // Clear riding on a valid term, with a bubble before it.
        term(1, 8'd3, 8'd3, 0, 0); term(0, 8'd9, 8'd9, 0, 0); term(1, 8'd2, 8'd2, 1, 1);
        idle(2);

        // Clear on a bubble discards the partial sum.
        term(1, 8'd7, 8'd7, 0, 0); term(0, 8'd0, 8'd0, 0, 1); term(1, 8'd3, 8'd3, 1, 0);
        idle(2);

        // 255*255: 1 signed, 65025 unsigned.
        term(1, 8'hFF, 8'hFF, 1, 0);
        idle(2);

        // Term counter saturates at 255.
        for (int i = 0; i < 300; i++) term(1, 8'd1, 8'd1, (i == 299), 0);
        idle(3);

        // Back-to-back results while the consumer stalls.
        i_result_ready = 1'b0;
        term(1, 8'd2, 8'd3, 1, 0); term(1, 8'd4, 8'd5, 1, 0);
        idle(4);
        i_result_ready = 1'b1;
        idle(1);
        i_result_ready = 1'b0;
        idle(2);
        i_result_ready = 1'b1;

        // Reset in the middle of an accumulation.
        term(1, 8'd5, 8'd5, 0, 0);
        do_reset();
        term(1, 8'd1, 8'd1, 1, 0);
        idle(3);

        // Randomized stream with bubbles, clears and a stalling consumer.
        for (int i = 0; i < 600; i++) begin
            i_result_ready = ($urandom_range(0, 9) < 7);
            term(($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end
        i_result_ready = 1'b1;
        idle(6);
        chk("drained", exp_q.size() + int'(pend_vld), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
